// File: rtl/mem_bus_master.sv
// mem_bus_master: turns CPU load/store requests into timed cycles on the shared 64-bit memory bus.
// One request in flight at a time; loads come back sign/zero-extended with a one-cycle response pulse.
module mem_bus_master #(
   parameter int READ_LATENCY = 2,
   parameter int WRITE_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] address,
   inout  wire  [63:0] data,
   output logic        mem_write,
   output logic        mem_read,
   output logic [1:0]  size,
   output logic [1:0]  dbg_state_o
);

   // Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready is
   // high only in IDLE. resp_valid pulses for one cycle and cannot be stalled by the consumer.

   localparam int MAX_CYC = (READ_LATENCY > WRITE_CYCLES) ? READ_LATENCY : WRITE_CYCLES;
   localparam int CW      = $clog2(MAX_CYC) + 1;
   localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
   localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept;
   logic          misaligned;

   logic [63:0]   wdata_q;
   logic [1:0]    rsize_q;
   logic          rsigned_q;

   logic [31:0]   address_q, address_d;
   logic [1:0]    size_q, size_d;
   logic          mem_write_q, mem_write_d;
   logic          mem_read_q, mem_read_d;
   logic          drive_q, drive_d;
   logic          resp_valid_q, resp_valid_d;
   logic          resp_fault_q, resp_fault_d;
   logic [63:0]   resp_rdata_q, resp_rdata_d;
   logic [63:0]   rdata_ext;

   assign accept = req_valid & req_ready;

   always_comb begin
      misaligned = 1'b0;
      case (req_size)
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = (req_addr[1:0] != 2'b00);
         2'b11:   misaligned = (req_addr[2:0] != 3'b000);
         default: misaligned = 1'b0;
      endcase
   end

   // Field is taken from the low bytes of the bus; the sign bit is the top bit of that field.
   always_comb begin
      rdata_ext = data;
      case (rsize_q)
         2'b00:   rdata_ext = {{56{rsigned_q & data[7]}},  data[7:0]};
         2'b01:   rdata_ext = {{48{rsigned_q & data[15]}}, data[15:0]};
         2'b10:   rdata_ext = {{32{rsigned_q & data[31]}}, data[31:0]};
         default: rdata_ext = data;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (misaligned) begin
                  state_d = S_RESP;
               end else if (req_write) begin
                  state_d = S_WRITE;
                  cnt_d   = WR_LOAD;
               end else begin
                  state_d = S_READ;
                  cnt_d   = RD_LOAD;
               end
            end
         end
         S_WRITE, S_READ: begin
            if (cnt_q == '0) state_d = S_RESP;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered bus/response outputs, decoded from the state being entered.
   always_comb begin
      req_ready    = (state_q == S_IDLE);
      mem_write_d  = (state_d == S_WRITE);
      mem_read_d   = (state_d == S_READ);
      drive_d      = (state_d == S_WRITE);
      resp_valid_d = (state_d == S_RESP);
      resp_fault_d = (state_q == S_IDLE) && (state_d == S_RESP);
      size_d       = 2'b00;
      address_d    = address_q;
      resp_rdata_d = resp_rdata_q;
      if (state_d == S_WRITE || state_d == S_READ) begin
         size_d = (state_q == S_IDLE) ? req_size : size_q;
         if (state_q == S_IDLE) address_d = req_addr;
      end
      if (state_d == S_RESP) resp_rdata_d = (state_q == S_READ) ? rdata_ext : 64'd0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         address_q    <= '0;
         size_q       <= '0;
         mem_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         drive_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_rdata_q <= '0;
         wdata_q      <= '0;
         rsize_q      <= '0;
         rsigned_q    <= 1'b0;
      end else begin
         address_q    <= address_d;
         size_q       <= size_d;
         mem_write_q  <= mem_write_d;
         mem_read_q   <= mem_read_d;
         drive_q      <= drive_d;
         resp_valid_q <= resp_valid_d;
         resp_fault_q <= resp_fault_d;
         resp_rdata_q <= resp_rdata_d;
         if (accept) begin
            wdata_q   <= req_wdata;
            rsize_q   <= req_size;
            rsigned_q <= req_signed;
         end
      end
   end

   assign data        = drive_q ? wdata_q : 64'bz;
   assign address     = address_q;
   assign size        = size_q;
   assign mem_write   = mem_write_q;
   assign mem_read    = mem_read_q;
   assign resp_valid  = resp_valid_q;
   assign resp_fault  = resp_fault_q;
   assign resp_rdata  = resp_rdata_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: default-timing instance plus a READ_LATENCY=4 instance,
// each with a simple read responder on its bus.
module tb_mem_bus_master;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] ZZ = {64{1'bz}};

   logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size  = 2'b00;
   logic [31:0] req_addr  = 32'd0;
   logic [63:0] req_wdata = 64'd0;
   logic        req_ready, resp_valid, resp_fault, mem_write, mem_read;
   logic [63:0] resp_rdata;
   logic [31:0] address;
   logic [1:0]  size, dbg_state;
   wire  [63:0] data;
   logic [63:0] rd_val = 64'd0;
   assign data = mem_read ? rd_val : 64'bz;

   logic        r4_valid = 1'b0, r4_write = 1'b0, r4_signed = 1'b0;
   logic [1:0]  r4_size  = 2'b00;
   logic [31:0] r4_addr  = 32'd0;
   logic [63:0] r4_wdata = 64'd0;
   logic        r4_ready, rv4, rf4, mw4, mr4;
   logic [63:0] rdata4;
   logic [31:0] addr4;
   logic [1:0]  size4, dbg4;
   wire  [63:0] data4;
   logic [63:0] rd4 = 64'd0;
   assign data4 = mr4 ? rd4 : 64'bz;

   mem_bus_master dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_fault(resp_fault), .address(address), .data(data), .mem_write(mem_write),
      .mem_read(mem_read), .size(size), .dbg_state_o(dbg_state)
   );

   mem_bus_master #(.READ_LATENCY(4), .WRITE_CYCLES(1)) dut4 (
      .clock(clock), .reset_n(reset_n), .req_valid(r4_valid), .req_ready(r4_ready),
      .req_write(r4_write), .req_size(r4_size), .req_signed(r4_signed), .req_addr(r4_addr),
      .req_wdata(r4_wdata), .resp_valid(rv4), .resp_rdata(rdata4),
      .resp_fault(rf4), .address(addr4), .data(data4), .mem_write(mw4),
      .mem_read(mr4), .size(size4), .dbg_state_o(dbg4)
   );

   task automatic test_reset();
      @(negedge clock);
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_fault !== 1'b0) begin
         errors++; $display("FAIL reset_hs: ready=%b rv=%b rf=%b expected 1 0 0", req_ready, resp_valid, resp_fault); end
      checks++; if (resp_rdata !== 64'd0 || address !== 32'd0 || size !== 2'b00) begin
         errors++; $display("FAIL reset_regs: rdata=%h addr=%h size=%b expected 0 0 0", resp_rdata, address, size); end
      checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || (data !== 64'd0 && data !== ZZ)) begin
         errors++; $display("FAIL reset_bus: wr=%b rd=%b data=%h expected 0 0 z", mem_write, mem_read, data); end
      checks++; if (r4_ready !== 1'b1 || rv4 !== 1'b0 || mr4 !== 1'b0) begin
         errors++; $display("FAIL reset_dut4: ready=%b rv=%b rd=%b expected 1 0 0", r4_ready, rv4, mr4); end
      reset_n = 1'b1;
   endtask

   // Called at a negedge with the DUT idle; leaves it idle at a negedge.
   task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [63:0] d);
      req_write = 1'b1; req_size = sz; req_signed = 1'b1; req_addr = a; req_wdata = d; req_valid = 1'b1;
      @(negedge clock);
      req_valid = 1'b0;
      checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
         errors++; $display("FAIL store_strobe: wr=%b rd=%b rv=%b ready=%b expected 1 0 0 0", mem_write, mem_read, resp_valid, req_ready); end
      checks++; if (data !== d || address !== a || size !== sz) begin
         errors++; $display("FAIL store_bus: data=%h addr=%h size=%b expected %h %h %b", data, address, size, d, a, sz); end
      @(negedge clock);
      checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_rdata !== 64'd0 || mem_write !== 1'b0) begin
         errors++; $display("FAIL store_resp: rv=%b rf=%b rdata=%h wr=%b expected 1 0 0 0", resp_valid, resp_fault, resp_rdata, mem_write); end
      checks++; if ((data !== 64'd0 && data !== ZZ) || size !== 2'b00 || address !== a) begin
         errors++; $display("FAIL store_after: data=%h size=%b addr=%h expected z 0 %h", data, size, address, a); end
      @(negedge clock);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL store_idle: rv=%b ready=%b expected 0 1", resp_valid, req_ready); end
   endtask

   task automatic do_load(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [63:0] d, input logic [63:0] exp);
      rd_val = d; req_write = 1'b0; req_size = sz; req_signed = sg; req_addr = a; req_valid = 1'b1;
      @(negedge clock);
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL load_strobe c%0d: rd=%b wr=%b rv=%b expected 1 0 0", i, mem_read, mem_write, resp_valid); end
         checks++; if (address !== a || size !== sz) begin
            errors++; $display("FAIL load_addr c%0d: addr=%h size=%b expected %h %b", i, address, size, a, sz); end
         @(negedge clock);
      end
      checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_rdata !== exp || mem_read !== 1'b0) begin
         errors++; $display("FAIL load_resp: rv=%b rf=%b rdata=%h rd=%b expected 1 0 %h 0", resp_valid, resp_fault, resp_rdata, mem_read, exp); end
      @(negedge clock);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL load_idle: rv=%b ready=%b expected 0 1", resp_valid, req_ready); end
   endtask

   task automatic test_store();
      do_store(2'b11, 32'h10, 64'h1122334455667788);
      do_store(2'b00, 32'h11, 64'h00000000000000AB);
   endtask

   task automatic test_load_ext();
      do_load(2'b00, 1'b1, 32'h13, 64'h0123456789ABCD80, 64'hFFFFFFFFFFFFFF80);
      do_load(2'b00, 1'b0, 32'h13, 64'h0123456789ABCD80, 64'h0000000000000080);
      do_load(2'b01, 1'b1, 32'h0A, 64'h1111222233338123, 64'hFFFFFFFFFFFF8123);
      do_load(2'b10, 1'b1, 32'h14, 64'h5555666680000001, 64'hFFFFFFFF80000001);
      do_load(2'b10, 1'b0, 32'h14, 64'h5555666680000001, 64'h0000000080000001);
      do_load(2'b11, 1'b1, 32'h18, 64'h8877665544332211, 64'h8877665544332211);
   endtask

   task automatic test_misaligned();
      logic [1:0]  szs [3] = '{2'b10, 2'b01, 2'b11};
      logic [31:0] adrs[3] = '{32'h06, 32'h01, 32'h0C};
      for (int k = 0; k < 3; k++) begin
         req_write = 1'b0; req_size = szs[k]; req_signed = 1'b1; req_addr = adrs[k]; req_valid = 1'b1;
         @(negedge clock);
         req_valid = 1'b0;
         checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_rdata !== 64'd0) begin
            errors++; $display("FAIL mis_resp k%0d: rv=%b rf=%b rdata=%h expected 1 1 0", k, resp_valid, resp_fault, resp_rdata); end
         checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || size !== 2'b00 || address !== 32'h18) begin
            errors++; $display("FAIL mis_bus k%0d: rd=%b wr=%b size=%b addr=%h expected 0 0 0 18", k, mem_read, mem_write, size, address); end
         @(negedge clock);
         checks++; if (resp_valid !== 1'b0 || resp_fault !== 1'b0 || req_ready !== 1'b1 || mem_read !== 1'b0) begin
            errors++; $display("FAIL mis_idle k%0d: rv=%b rf=%b ready=%b rd=%b expected 0 0 1 0", k, resp_valid, resp_fault, req_ready, mem_read); end
      end
   endtask

   task automatic test_back_to_back();
      logic exp_wr [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
      logic exp_rd [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
      logic exp_rv [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
      logic exp_rdy[8] = '{1, 0, 0, 1, 0, 0, 0, 1};
      rd_val = 64'hF0E1D2C3B4A59687;
      req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h20;
      req_wdata = 64'hDEADBEEFCAFEF00D; req_valid = 1'b1;
      for (int c = 1; c < 8; c++) begin
         @(negedge clock);
         if (c == 1) begin
            req_write = 1'b0; req_size = 2'b11; req_addr = 32'h28; req_wdata = 64'h0123012301230123;
            #1;
         end
         if (c == 4) req_valid = 1'b0;
         checks++; if (mem_write !== exp_wr[c] || mem_read !== exp_rd[c] || resp_valid !== exp_rv[c] || req_ready !== exp_rdy[c]) begin
            errors++; $display("FAIL b2b_ctl c%0d: wr=%b rd=%b rv=%b ready=%b expected %b %b %b %b", c,
               mem_write, mem_read, resp_valid, req_ready, exp_wr[c], exp_rd[c], exp_rv[c], exp_rdy[c]); end
         if (c == 1) begin
            checks++; if (data !== 64'hDEADBEEFCAFEF00D || address !== 32'h20 || size !== 2'b10) begin
               errors++; $display("FAIL b2b_store: data=%h addr=%h size=%b expected deadbeefcafef00d 20 10", data, address, size); end
         end else if (c != 4 && c != 5) begin
            checks++; if (data !== 64'd0 && data !== ZZ) begin
               errors++; $display("FAIL b2b_dataz c%0d: data=%h expected z", c, data); end
         end
         if (c == 4) begin
            checks++; if (address !== 32'h28 || size !== 2'b11) begin
               errors++; $display("FAIL b2b_load: addr=%h size=%b expected 28 11", address, size); end
         end
         if (c == 2 || c == 6) begin
            checks++; if (resp_rdata !== ((c == 2) ? 64'd0 : 64'hF0E1D2C3B4A59687)) begin
               errors++; $display("FAIL b2b_rdata c%0d: rdata=%h", c, resp_rdata); end
         end
      end
   endtask

   task automatic test_reset_mid_read();
      rd_val = 64'h00000000DEADBEEF;
      req_write = 1'b0; req_size = 2'b10; req_signed = 1'b1; req_addr = 32'h30; req_valid = 1'b1;
      @(negedge clock);
      req_valid = 1'b0;
      checks++; if (mem_read !== 1'b1) begin
         errors++; $display("FAIL rst_pre: rd=%b expected 1", mem_read); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (mem_read !== 1'b0 || (data !== 64'd0 && data !== ZZ) || resp_valid !== 1'b0) begin
         errors++; $display("FAIL rst_now: rd=%b data=%h rv=%b expected 0 z 0", mem_read, data, resp_valid); end
      checks++; if (req_ready !== 1'b1 || address !== 32'd0 || size !== 2'b00) begin
         errors++; $display("FAIL rst_regs: ready=%b addr=%h size=%b expected 1 0 0", req_ready, address, size); end
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checks++; if (resp_valid !== 1'b0 || mem_read !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_after c%0d: rv=%b rd=%b ready=%b expected 0 0 1", i, resp_valid, mem_read, req_ready); end
      end
   endtask

   task automatic do_load4(input logic [63:0] d, input logic [63:0] exp);
      rd4 = d; r4_write = 1'b0; r4_size = 2'b01; r4_signed = 1'b1; r4_addr = 32'h2; r4_valid = 1'b1;
      @(negedge clock);
      r4_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (mr4 !== 1'b1 || rv4 !== 1'b0 || addr4 !== 32'h2 || size4 !== 2'b01) begin
            errors++; $display("FAIL lat4_read c%0d: rd=%b rv=%b addr=%h size=%b expected 1 0 2 01", i, mr4, rv4, addr4, size4); end
         @(negedge clock);
      end
      checks++; if (rv4 !== 1'b1 || rdata4 !== exp || mr4 !== 1'b0 || rf4 !== 1'b0) begin
         errors++; $display("FAIL lat4_resp: rv=%b rdata=%h rd=%b rf=%b expected 1 %h 0 0", rv4, rdata4, mr4, rf4, exp); end
      @(negedge clock);
      checks++; if (rv4 !== 1'b0 || r4_ready !== 1'b1) begin
         errors++; $display("FAIL lat4_idle: rv=%b ready=%b expected 0 1", rv4, r4_ready); end
   endtask

   task automatic test_latency4();
      do_load4(64'hABCD000012347FFF, 64'h0000000000007FFF);
      do_load4(64'h0000000000008001, 64'hFFFFFFFFFFFF8001);
   endtask

   initial begin
      test_reset();
      @(negedge clock);
      test_store();
      test_load_ext();
      test_misaligned();
      test_back_to_back();
      test_reset_mid_read();
      test_latency4();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
